// File: rtl/w_mat_rd_ctrl_if.sv
// Bundle of the controller's command, weight-memory and output-row signals.
// The slave side is the controller; the master side is whoever drives it.
interface w_mat_rd_ctrl_if #(
  parameter int IN_C    = 34,
  parameter int OUT_C   = 32,
  parameter int W_WIDTH = 8
);
  localparam int IDX_W = $clog2(IN_C);
  localparam int VEC_W = OUT_C * W_WIDTH;

  logic             start;
  logic [IDX_W-1:0] cfg_first;
  logic [IDX_W-1:0] cfg_last;
  logic             busy;
  logic             done;
  logic             cfg_err;
  logic             mem_rd_en;
  logic [IDX_W-1:0] mem_idx;
  logic [VEC_W-1:0] mem_rdata;
  logic             w_valid;
  logic             w_ready;
  logic [VEC_W-1:0] w_vec;
  logic [IDX_W-1:0] w_idx;
  logic             w_last;

  modport master (
    output start, cfg_first, cfg_last, mem_rdata, w_ready,
    input  busy, done, cfg_err, mem_rd_en, mem_idx, w_valid, w_vec, w_idx, w_last
  );

  modport slave (
    input  start, cfg_first, cfg_last, mem_rdata, w_ready,
    output busy, done, cfg_err, mem_rd_en, mem_idx, w_valid, w_vec, w_idx, w_last
  );
endinterface

// File: rtl/w_mat_rd_ctrl.sv
// Streams weight-matrix rows cfg_first..cfg_last from a 1-cycle-latency memory
// into a 2-entry FWFT buffer, issuing reads only when buffer space is guaranteed.
module w_mat_rd_ctrl #(
  parameter int IN_C    = 34,
  parameter int OUT_C   = 32,
  parameter int W_WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  w_mat_rd_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(IN_C);
  localparam int VEC_W = OUT_C * W_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                      state, state_nxt;
  logic [IDX_W-1:0]            last_q, idx_q, idx_inc, issue_idx;
  logic                        pend, issue, push, pop, range_ok, head_last;
  logic [1:0]                  cnt, in_use;
  logic                        wr_ptr, rd_ptr;
  logic [1:0][VEC_W-1:0]       f_vec;
  logic [1:0][IDX_W-1:0]       f_idx;
  logic [1:0]                  f_last;

  assign range_ok  = (bus.cfg_first <= bus.cfg_last) && (int'(bus.cfg_last) < IN_C);
  assign idx_inc   = idx_q + 1'b1;
  assign push      = pend;
  assign pop       = bus.w_valid && bus.w_ready;
  assign head_last = f_last[rd_ptr];
  // Slots already claimed after this cycle's pop: buffered rows plus the read in flight.
  assign in_use    = cnt + {1'b0, pend} - {1'b0, pop};

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    issue_idx = idx_q;
    unique case (state)
      IDLE: if (bus.start && range_ok) begin
        // First read goes out in the start cycle so the first row is valid two cycles later.
        issue     = 1'b1;
        issue_idx = bus.cfg_first;
        state_nxt = (bus.cfg_first == bus.cfg_last) ? DRAIN : RUN;
      end
      RUN: if (in_use < 2'd2) begin
        issue     = 1'b1;
        issue_idx = idx_inc;
        if (idx_inc == last_q) state_nxt = DRAIN;
      end
      DRAIN: if (pop && head_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      issue     = 1'b0;
      issue_idx = idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_q      <= '0;
      idx_q       <= '0;
      pend        <= 1'b0;
      bus.cfg_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      pend        <= issue;
      bus.cfg_err <= (state == IDLE) && bus.start && !range_ok;
      if (issue) idx_q <= issue_idx;
      if (state == IDLE && bus.start && range_ok) last_q <= bus.cfg_last;
    end
  end

  // idx_q still names the read returning this cycle, so it tags the pushed row.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= '0;
      f_idx  <= '0;
      f_last <= '0;
    end else begin
      if (push) begin
        f_idx[wr_ptr]  <= idx_q;
        f_last[wr_ptr] <= (idx_q == last_q);
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) f_vec[wr_ptr] <= bus.mem_rdata;
  end

  assign bus.mem_rd_en = issue;
  assign bus.mem_idx   = issue_idx;
  assign bus.busy      = (state != IDLE);
  assign bus.w_valid   = (cnt != 2'd0) && !rst;
  assign bus.w_vec     = f_vec[rd_ptr];
  assign bus.w_idx     = f_idx[rd_ptr];
  assign bus.w_last    = head_last && bus.w_valid;
  assign bus.done      = (state == DRAIN) && pop && head_last;
endmodule

// File: tb/tb_w_mat_rd_ctrl.sv
// Bench for w_mat_rd_ctrl: vector table, random passes and reset/restart sequences,
// with a row-queue reference model and a per-cycle protocol monitor.
module tb_w_mat_rd_ctrl;
  localparam int IN_C = 34, OUT_C = 32, W_WIDTH = 8;
  localparam int IDX_W = 6, VEC_W = 256;

  logic clk, rst;
  int   tests = 0, fails = 0;

  w_mat_rd_ctrl_if #(.IN_C(IN_C), .OUT_C(OUT_C), .W_WIDTH(W_WIDTH)) bus ();
  w_mat_rd_ctrl #(.IN_C(IN_C), .OUT_C(OUT_C), .W_WIDTH(W_WIDTH)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] mword(input int idx);
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = (idx * 32'h9E3779B1) ^ (k * 32'h01010101) ^ 32'hC3A50000;
    return v;
  endfunction

  // Weight memory: data for the addressed row one cycle after a read, garbage otherwise.
  always @(posedge clk)
    bus.mem_rdata <= bus.mem_rd_en ? mword(int'(bus.mem_idx)) : {8{$urandom()}};

  // Reference model: the rows a pass must deliver, in order.
  int exp_q[$];
  int exp_first = 0, rd_base = 0, hs_base = 0;
  int tot_reads = 0, tot_hs = 0;
  bit p_ok = 0, p_stall = 0, p_last = 0;
  logic [IDX_W-1:0] p_midx, p_idx;
  logic [VEC_W-1:0] p_vec;

  always @(negedge clk) begin
    bit hs, exp_done, is_last;
    int e;
    if (rst) p_ok = 0;
    else begin
      if (bus.mem_rd_en) begin
        chk("rd_idx", bus.mem_idx, exp_first + (tot_reads - rd_base));
        tot_reads++;
      end else if (p_ok) chk("idx_hold", bus.mem_idx, p_midx);
      if (p_ok && p_stall) begin
        chk("stall_valid", bus.w_valid, 1);
        chk("stall_idx", bus.w_idx, p_idx);
        chk("stall_vec", bus.w_vec, p_vec);
        chk("stall_last", bus.w_last, p_last);
      end
      hs = bus.w_valid && bus.w_ready;
      exp_done = 0;
      if (hs) begin
        tot_hs++;
        chk("row_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          is_last = (exp_q.size() == 0);
          chk("row_idx", bus.w_idx, e);
          chk("row_vec", bus.w_vec, mword(e));
          chk("row_last", bus.w_last, is_last);
          exp_done = is_last;
        end
      end
      chk("done", bus.done, exp_done);
      chk("in_flight", ((tot_reads - rd_base) - (tot_hs - hs_base)) <= 2, 1);
      p_ok = 1;
      p_stall = bus.w_valid && !bus.w_ready;
      p_midx = bus.mem_idx; p_idx = bus.w_idx; p_vec = bus.w_vec; p_last = bus.w_last;
    end
  end

  function automatic logic rdy(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 4 == 0) || (c % 4 == 3);
      default: return 1'(($urandom() >> 3) & 1);
    endcase
  endfunction

  task automatic zero_chk(input string nm);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_done"}, bus.done, 0);
    chk({nm, "_cfg_err"}, bus.cfg_err, 0);
    chk({nm, "_rd_en"}, bus.mem_rd_en, 0);
    chk({nm, "_mem_idx"}, bus.mem_idx, 0);
    chk({nm, "_w_valid"}, bus.w_valid, 0);
    chk({nm, "_w_last"}, bus.w_last, 0);
    chk({nm, "_w_idx"}, bus.w_idx, 0);
  endtask

  // One pass from start to completion; poke >= 0 re-pulses start at that cycle.
  task automatic do_vec(input string nm, input int f, input int l, input int mode, input int poke,
                        input bit exp_err, input int exp_rows, input int exp_lat);
    bit ok, fin, busy_seen, busy_after;
    int err, rows, lat, dcyc, dones;
    ok = (f <= l) && (l < IN_C);
    err = 0; rows = 0; lat = -1; dcyc = -1; dones = 0; fin = 0; busy_seen = 0; busy_after = 1;
    rd_base = tot_reads; hs_base = tot_hs; exp_first = f;
    if (ok) for (int i = f; i <= l; i++) exp_q.push_back(i);
    bus.start = 1'b1; bus.cfg_first = IDX_W'(f); bus.cfg_last = IDX_W'(l); bus.w_ready = rdy(mode, 0);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (bus.w_valid && lat < 0) lat = c;
      if (bus.w_valid && bus.w_ready) rows++;
      if (bus.cfg_err) err++;
      if (bus.busy) busy_seen = 1;
      if (dones > 0 && c == dcyc + 1) begin busy_after = bus.busy; fin = 1; break; end
      if (bus.done) begin dones++; dcyc = c; end
      if (!ok && c == 3) begin fin = 1; break; end
      @(posedge clk); #1;
      bus.start = (c + 1 == poke);
      if (c + 1 == poke) begin bus.cfg_first = 6'd10; bus.cfg_last = 6'd3; end
      bus.w_ready = rdy(mode, c + 1);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({nm, "_finished"}, fin, 1);
    chk({nm, "_cfg_err"}, err, exp_err);
    chk({nm, "_rows"}, rows, exp_rows);
    chk({nm, "_reads"}, tot_reads - rd_base, exp_rows);
    chk({nm, "_dones"}, dones, exp_rows > 0);
    if (exp_err) chk({nm, "_busy_idle"}, busy_seen, 0);
    else chk({nm, "_busy_drop"}, busy_after, 0);
    if (exp_lat >= 0) begin
      chk({nm, "_latency"}, lat, exp_lat);
      chk({nm, "_done_cyc"}, dcyc, exp_lat + exp_rows - 1);
    end
  endtask

  typedef struct {
    int f, l, mode, poke;
    bit exp_err;
    int exp_rows, exp_lat;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{f: 0,  l: 33, mode: 0, poke: -1, exp_err: 0, exp_rows: 34, exp_lat: 2};
    vt[1] = '{f: 5,  l: 5,  mode: 0, poke: -1, exp_err: 0, exp_rows: 1,  exp_lat: 2};
    vt[2] = '{f: 10, l: 3,  mode: 0, poke: -1, exp_err: 1, exp_rows: 0,  exp_lat: -1};
    vt[3] = '{f: 0,  l: 34, mode: 0, poke: -1, exp_err: 1, exp_rows: 0,  exp_lat: -1};
    vt[4] = '{f: 0,  l: 7,  mode: 1, poke: -1, exp_err: 0, exp_rows: 8,  exp_lat: -1};
    vt[5] = '{f: 0,  l: 33, mode: 0, poke: 5,  exp_err: 0, exp_rows: 34, exp_lat: 2};
    vt[6] = '{f: 33, l: 33, mode: 0, poke: -1, exp_err: 0, exp_rows: 1,  exp_lat: 2};
    vt[7] = '{f: 30, l: 33, mode: 2, poke: -1, exp_err: 0, exp_rows: 4,  exp_lat: -1};

    rst = 1'b1; bus.start = 1'b0; bus.cfg_first = '0; bus.cfg_last = '0; bus.w_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    zero_chk("reset");
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++)
      do_vec($sformatf("v%0d", i), vt[i].f, vt[i].l, vt[i].mode, vt[i].poke,
             vt[i].exp_err, vt[i].exp_rows, vt[i].exp_lat);

    // Abort a full pass three cycles in; nothing of it may surface afterwards.
    rd_base = tot_reads; hs_base = tot_hs; exp_first = 0;
    for (int i = 0; i <= 33; i++) exp_q.push_back(i);
    bus.start = 1'b1; bus.cfg_first = 6'd0; bus.cfg_last = 6'd33; bus.w_ready = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    zero_chk("abort");
    repeat (3) @(posedge clk);
    #1;
    do_vec("after_abort", 0, 33, 0, -1, 0, 34, 2);

    for (int i = 0; i < 15; i++) begin
      int f, l;
      bit ok;
      f = $urandom_range(0, 33);
      l = $urandom_range(0, 40);
      ok = (f <= l) && (l < IN_C);
      do_vec($sformatf("rnd%0d", i), f, l, 2, -1, !ok, ok ? l - f + 1 : 0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/w_mat_rd_ctrl.md
W_MAT_RD_CTRL -- requirements
Module: w_mat_rd_ctrl

Interface
REQ-001 SHALL have parameter IN_C, default 34: number of weight-matrix input-channel rows.
REQ-002 SHALL have parameter OUT_C, default 32: number of output channels per row.
REQ-003 SHALL have parameter W_WIDTH, default 8: bits per weight.
REQ-004 SHALL derive IDX_W = $clog2(IN_C) and VEC_W = OUT_C*W_WIDTH.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle request to stream rows cfg_first..cfg_last.
REQ-008 cfg_first  in  IDX_W  first row index; sampled only when start is accepted.
REQ-009 cfg_last  in  IDX_W  last row index, inclusive; sampled only when start is accepted.
REQ-010 busy  out  1  high from accepted start until done.
REQ-011 done  out  1  one-cycle pulse at end of pass.
REQ-012 cfg_err  out  1  one-cycle pulse when start is rejected for an illegal range.
REQ-013 mem_rd_en  out  1  read enable to the weight memory.
REQ-014 mem_idx  out  IDX_W  row address to the weight memory.
REQ-015 mem_rdata  in  VEC_W  memory read data, valid exactly 1 cycle after mem_rd_en.
REQ-016 w_valid  out  1  output row valid.
REQ-017 w_ready  in  1  downstream accepts the row when w_valid and w_ready are both high.
REQ-018 w_vec  out  VEC_W  output weight row.
REQ-019 w_idx  out  IDX_W  row index of w_vec.
REQ-020 w_last  out  1  high with the row whose index equals cfg_last.

Function
REQ-021 SHALL implement states IDLE, RUN and DRAIN.
REQ-022 IDLE: start with cfg_first<=cfg_last<IN_C SHALL latch the range, set busy next cycle and go to RUN.
REQ-023 IDLE: start with an illegal range SHALL pulse cfg_err next cycle, issue no read and stay IDLE.
REQ-024 start while busy SHALL be ignored, with no latch and no cfg_err.
REQ-025 RUN: SHALL issue one read per cycle while credits allow, starting at cfg_first and incrementing by 1.
REQ-026 Credit rule: SHALL issue a read only when outstanding reads (0/1) plus 2-entry output FIFO occupancy, after the same-cycle pop, is less than 2.
REQ-027 Because of REQ-026, the FIFO SHALL never overflow and SHALL never drop a row.
REQ-028 mem_idx SHALL be held stable when mem_rd_en is low; mem_idx never exceeds the latched cfg_last.
REQ-029 Each returned mem_rdata SHALL be written into the FIFO together with its index and a last flag.
REQ-030 Simultaneous FIFO push and pop SHALL be legal in any occupancy, including full.
REQ-031 The FIFO SHALL be first-word-fall-through: w_valid = FIFO not empty, and w_vec/w_idx/w_last come from the head.
REQ-032 w_vec, w_idx and w_last SHALL stay stable while w_valid=1 and w_ready=0.
REQ-033 After the read of cfg_last is issued, the block SHALL go to DRAIN.
REQ-034 DRAIN: on the handshake of the w_last row, the block SHALL pulse done in the same cycle, drop busy next cycle and return to IDLE.
REQ-035 Latency: with w_ready held high, the first w_valid SHALL appear 2 cycles after start; throughput SHALL be 1 row per cycle.
REQ-036 A single-row range (cfg_first==cfg_last) SHALL produce exactly one row, with w_last=1.
REQ-037 A pass of N rows SHALL issue exactly N reads and produce exactly N handshakes, in ascending index order.

Reset
REQ-038 rst SHALL force IDLE, clear FIFO pointers and the outstanding-read flag, and drive busy, done, cfg_err, mem_rd_en, w_valid and w_last to 0.
REQ-039 rst SHALL drive mem_idx and w_idx to 0; w_vec is unspecified while w_valid=0.
REQ-040 rst asserted mid-pass SHALL abort the pass: no done pulse, and data returning in the following cycle is discarded.
REQ-041 rst SHALL have priority over start in the same cycle.

Verification
REQ-042 IN_C=34, start with first=0 and last=33, w_ready=1 -> 34 rows with idx 0..33 on consecutive cycles, first valid at start+2, w_last on idx 33, done in the same cycle as that handshake.
REQ-043 first=5, last=5 -> one mem read at idx 5, one row with w_last=1, then done.
REQ-044 first=10, last=3 -> cfg_err pulse, no mem_rd_en, busy stays 0; same for last=34.
REQ-045 first=0, last=7 with w_ready toggling 1-0-0-1 -> at most 2 rows buffered, no row lost or duplicated, w_vec stable while stalled, all 8 idx in order.
REQ-046 rst asserted 3 cycles into a 0..33 pass -> all outputs 0 next cycle, no done; a new start then completes normally.
REQ-047 start pulsed again mid-pass -> ignored; only the original range is produced.
